// File: rtl/mem_port_arbiter_pkg.sv
// Shared owner and size encodings for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// SRAM-like request/response port; master issues requests, slave answers them.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_port_arbiter_fifo.sv
// In-order 1-bit owner FIFO: remembers which requester issued each outstanding transaction.
module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = slots[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; responses return in order.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of data priority with starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input logic                clk,
  input logic                resetn,
  mem_port_arbiter_if.slave  inst_bus,
  mem_port_arbiter_if.slave  data_bus,
  mem_port_arbiter_if.master mem_bus
);

  owner_e            sel;
  logic              sel_valid;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [3:0]        sel_wstrb;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              lock_q;
  owner_e            lock_owner_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_head;
  logic              mem_req;
  logic              accept;
  logic              inst_accept;
  logic              resp_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_grant_q;
`else
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt_q;
`endif

  // A locked owner keeps the port until the downstream accepts its request.
  always_comb begin
    sel       = OWNER_DATA;
    sel_valid = 1'b0;
    if (lock_q) begin
      sel       = lock_owner_q;
      sel_valid = (lock_owner_q == OWNER_INST) ? inst_bus.req : data_bus.req;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    else if (inst_bus.req && data_bus.req) begin
      sel       = (last_grant_q == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
      sel_valid = 1'b1;
    end
`else
    else if (inst_bus.req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT))) begin
      sel       = OWNER_INST;
      sel_valid = 1'b1;
    end
`endif
    else if (data_bus.req) begin
      sel       = OWNER_DATA;
      sel_valid = 1'b1;
    end else if (inst_bus.req) begin
      sel       = OWNER_INST;
      sel_valid = 1'b1;
    end
  end

  always_comb begin
    sel_wr    = data_bus.wr;
    sel_size  = data_bus.size;
    sel_wstrb = data_bus.wstrb;
    sel_addr  = data_bus.addr;
    sel_wdata = data_bus.wdata;
    if (sel == OWNER_INST) begin
      sel_wr    = inst_bus.wr;
      sel_size  = inst_bus.size;
      sel_wstrb = inst_bus.wstrb;
      sel_addr  = inst_bus.addr;
      sel_wdata = inst_bus.wdata;
    end
  end

  // Outputs are forced low while reset is held, independent of requester inputs.
  assign mem_req     = resetn & sel_valid & ~fifo_full;
  assign accept      = mem_req & mem_bus.addr_ok;
  assign inst_accept = accept & (sel == OWNER_INST);
  assign resp_valid  = resetn & mem_bus.data_ok & ~fifo_empty;

  assign mem_bus.req   = mem_req;
  assign mem_bus.wr    = resetn & sel_wr;
  assign mem_bus.size  = resetn ? sel_size : '0;
  assign mem_bus.wstrb = resetn ? sel_wstrb : '0;
  assign mem_bus.addr  = resetn ? sel_addr : '0;
  assign mem_bus.wdata = resetn ? sel_wdata : '0;

  assign inst_bus.addr_ok = inst_accept;
  assign data_bus.addr_ok = accept & (sel == OWNER_DATA);
  assign inst_bus.data_ok = resp_valid & (owner_e'(fifo_head) == OWNER_INST);
  assign data_bus.data_ok = resp_valid & (owner_e'(fifo_head) == OWNER_DATA);
  assign inst_bus.rdata   = resetn ? mem_bus.rdata : '0;
  assign data_bus.rdata   = resetn ? mem_bus.rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
    end else if (mem_req && !mem_bus.addr_ok) begin
      lock_q       <= 1'b1;
      lock_owner_q <= sel;
    end else if (accept) begin
      lock_q       <= 1'b0;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Starting from DATA lets instruction fetch win the first contested grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= OWNER_DATA;
    end else if (accept) begin
      last_grant_q <= sel;
    end
  end
`else
  // Counts cycles fetch waits behind data; saturates so fetch wins the next grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
    end else if (inst_accept || !inst_bus.req) begin
      starve_cnt_q <= '0;
    end else if (sel_valid && (sel == OWNER_DATA) &&
                 (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`endif

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (resp_valid),
    .din    (sel),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an in-order owner scoreboard for responses.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ACC_NONE = 0;
  localparam int ACC_INST = 1;
  localparam int ACC_DATA = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  owner_e sb_q[$];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .mem_bus  (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic drive_inst(input logic req, input logic [31:0] addr);
    inst_if.req   = req;
    inst_if.addr  = addr;
    inst_if.wr    = 1'b0;
    inst_if.size  = SIZE_W;
    inst_if.wstrb = 4'hF;
    inst_if.wdata = '0;
  endtask

  task automatic drive_data(input logic req, input logic [31:0] addr, input logic wr,
                            input logic [1:0] size, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
    data_if.req   = req;
    data_if.addr  = addr;
    data_if.wr    = wr;
    data_if.size  = size;
    data_if.wstrb = wstrb;
    data_if.wdata = wdata;
  endtask

  task automatic drive_mem(input logic addr_ok, input logic data_ok, input logic [31:0] rdata);
    mem_if.addr_ok = addr_ok;
    mem_if.data_ok = data_ok;
    mem_if.rdata   = rdata;
  endtask

  // Checks one cycle's grant and response, then advances to the next negedge.
  task automatic cycle_check(input string tag, input logic exp_req, input int exp_acc);
    owner_e own;
    #1;
    check_output({tag, ".mem_req"}, 32'(mem_if.req), 32'(exp_req));
    check_output({tag, ".inst_aok"}, 32'(inst_if.addr_ok), 32'(exp_acc == ACC_INST));
    check_output({tag, ".data_aok"}, 32'(data_if.addr_ok), 32'(exp_acc == ACC_DATA));
    if (mem_if.data_ok && sb_q.size() != 0) begin
      own = sb_q.pop_front();
      check_output({tag, ".inst_dok"}, 32'(inst_if.data_ok), 32'(own == OWNER_INST));
      check_output({tag, ".data_dok"}, 32'(data_if.data_ok), 32'(own == OWNER_DATA));
      if (own == OWNER_INST) check_output({tag, ".inst_rdata"}, inst_if.rdata, mem_if.rdata);
      else                   check_output({tag, ".data_rdata"}, data_if.rdata, mem_if.rdata);
    end else begin
      check_output({tag, ".inst_dok"}, 32'(inst_if.data_ok), 32'd0);
      check_output({tag, ".data_dok"}, 32'(data_if.data_ok), 32'd0);
    end
    if (exp_acc == ACC_INST) begin
      check_output({tag, ".addr"}, mem_if.addr, inst_if.addr);
      sb_q.push_back(OWNER_INST);
    end else if (exp_acc == ACC_DATA) begin
      check_output({tag, ".addr"}, mem_if.addr, data_if.addr);
      sb_q.push_back(OWNER_DATA);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, ".mem_req"}, 32'(mem_if.req), 32'd0);
    check_output({tag, ".mem_addr"}, mem_if.addr, 32'd0);
    check_output({tag, ".mem_wstrb"}, 32'(mem_if.wstrb), 32'd0);
    check_output({tag, ".mem_size"}, 32'(mem_if.size), 32'd0);
    check_output({tag, ".inst_aok"}, 32'(inst_if.addr_ok), 32'd0);
    check_output({tag, ".inst_dok"}, 32'(inst_if.data_ok), 32'd0);
    check_output({tag, ".data_dok"}, 32'(data_if.data_ok), 32'd0);
    check_output({tag, ".inst_rdata"}, inst_if.rdata, 32'd0);
    check_output({tag, ".data_rdata"}, data_if.rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    drive_inst(1'b1, 32'h1C00_0000);
    drive_data(1'b0, 32'h0, 1'b0, SIZE_W, 4'hF, 32'h0);
    drive_mem(1'b1, 1'b1, 32'h5A5A_5A5A);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Both requesting continuously: inst, data, inst, data ...
    drive_inst(1'b1, 32'h1C00_0000);
    drive_data(1'b1, 32'h8000_0000, 1'b0, SIZE_W, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive_mem(1'b1, i > 0, 32'h100 + 32'(i));
      cycle_check($sformatf("rr%0d", i), 1'b1, (i % 2 == 0) ? ACC_INST : ACC_DATA);
    end
`else
    // Data wins four cycles, then the starved fetch gets one grant, then the pattern repeats.
    drive_inst(1'b1, 32'h1C00_0000);
    drive_data(1'b1, 32'h8000_0000, 1'b0, SIZE_W, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      drive_mem(1'b1, i > 0, 32'h100 + 32'(i));
      cycle_check($sformatf("starve%0d", i), 1'b1, (i == 4 || i == 9) ? ACC_INST : ACC_DATA);
    end
`endif
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 32'h0, 1'b0, SIZE_W, 4'hF, 32'h0);
    drive_mem(1'b0, 1'b1, 32'h0000_0777);
    cycle_check("drain", 1'b0, ACC_NONE);

    // Fetch holds the port while addr_ok is low, even after data starts requesting.
    drive_mem(1'b0, 1'b0, 32'h0);
    drive_inst(1'b1, 32'h1C00_0000);
    cycle_check("lock0", 1'b1, ACC_NONE);
    drive_data(1'b1, 32'h8000_0010, 1'b1, SIZE_H, 4'b0011, 32'hCAFE_0000);
    #1;
    check_output("lock1.addr", mem_if.addr, 32'h1C00_0000);
    cycle_check("lock1", 1'b1, ACC_NONE);
    cycle_check("lock2", 1'b1, ACC_NONE);
    drive_mem(1'b1, 1'b0, 32'h0);
    cycle_check("lock3", 1'b1, ACC_INST);
    drive_inst(1'b0, 32'h0);
    #1;
    check_output("mux.wr", 32'(mem_if.wr), 32'd1);
    check_output("mux.size", 32'(mem_if.size), 32'(SIZE_H));
    check_output("mux.wstrb", 32'(mem_if.wstrb), 32'h3);
    check_output("mux.wdata", mem_if.wdata, 32'hCAFE_0000);
    cycle_check("lock4", 1'b1, ACC_DATA);
    drive_data(1'b0, 32'h0, 1'b0, SIZE_W, 4'hF, 32'h0);
    drive_mem(1'b1, 1'b1, 32'hAAAA_5555);
    cycle_check("order0", 1'b0, ACC_NONE);
    drive_mem(1'b1, 1'b1, 32'h1234_5678);
    cycle_check("order1", 1'b0, ACC_NONE);

    // Full FIFO blocks a new request even in the cycle a response pops.
    drive_mem(1'b1, 1'b0, 32'h0);
    drive_inst(1'b1, 32'h1C00_0040);
    cycle_check("full0", 1'b1, ACC_INST);
    drive_inst(1'b0, 32'h0);
    drive_data(1'b1, 32'h8000_0040, 1'b0, SIZE_W, 4'hF, 32'h0);
    cycle_check("full1", 1'b1, ACC_DATA);
    drive_data(1'b0, 32'h0, 1'b0, SIZE_W, 4'hF, 32'h0);
    drive_inst(1'b1, 32'h1C00_0044);
    cycle_check("full2", 1'b0, ACC_NONE);
    drive_mem(1'b1, 1'b1, 32'h0000_0011);
    cycle_check("full3", 1'b0, ACC_NONE);
    drive_mem(1'b1, 1'b1, 32'h0000_0022);
    cycle_check("full4", 1'b1, ACC_INST);
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b1, 1'b1, 32'h0000_0033);
    cycle_check("full5", 1'b0, ACC_NONE);

    // A response with nothing outstanding is ignored and must not disturb occupancy.
    drive_mem(1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle_check("empty0", 1'b0, ACC_NONE);
    drive_mem(1'b1, 1'b0, 32'h0);
    drive_inst(1'b1, 32'h1C00_0080);
    cycle_check("empty1", 1'b1, ACC_INST);
    drive_inst(1'b0, 32'h0);
    drive_data(1'b1, 32'h8000_0080, 1'b0, SIZE_W, 4'hF, 32'h0);
    cycle_check("empty2", 1'b1, ACC_DATA);
    drive_data(1'b0, 32'h0, 1'b0, SIZE_W, 4'hF, 32'h0);
    drive_inst(1'b1, 32'h1C00_0084);
    cycle_check("empty3", 1'b0, ACC_NONE);
    drive_mem(1'b0, 1'b1, 32'h0000_0044);
    cycle_check("empty4", 1'b0, ACC_NONE);

    // Reset with one transaction outstanding: outputs drop at once, FIFO comes back empty.
    drive_mem(1'b1, 1'b1, 32'h0000_BEEF);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    @(negedge clk);
    drive_inst(1'b0, 32'h0);
    resetn = 1'b1;
    drive_mem(1'b1, 1'b1, 32'h0000_0055);
    cycle_check("post0", 1'b0, ACC_NONE);
    drive_mem(1'b1, 1'b0, 32'h0);
    drive_inst(1'b1, 32'h1C00_00C0);
    cycle_check("post1", 1'b1, ACC_INST);
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b1, 1'b1, 32'h0000_0066);
    cycle_check("post2", 1'b0, ACC_NONE);

    check_output("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
